seg_display_arbiter: RTL and testbench

Time-shares the 8-digit seven-segment display between three requesters: the running game score (background), one-shot timed messages (e.g. "GAME OVER"), and a debug override. Sits between `score`/game logic and `sevensegment`, driving that block's `d0`–`d7` and `dp` inputs. Converts the 16-bit binary score to decimal with a sequential double-dabble engine so no wide combinational divider is needed.

---
 rtl/segarb_pkg.sv | 49 ++++
 rtl/seg_display_arbiter_bin2bcd_seq.sv | 69 ++++++
 rtl/seg_display_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segarb_pkg.sv
// ---------------------------------------------------------------------------
// segarb_pkg
// Shared constants, the arbiter state type and the score-view helper for
// seg_display_arbiter and its BCD converter.
//
// Build option: SEGARB_LZB_EN (define for leading-zero blanking of the
// score digits; undefined shows all five digits including leading zeros).
// ---------------------------------------------------------------------------
package segarb_pkg;

    localparam logic [4:0]  DIG_BLANK    = 5'h1F;

    localparam logic [1:0]  SRC_SCORE    = 2'd0;
    localparam logic [1:0]  SRC_MSG      = 2'd1;
    localparam logic [1:0]  SRC_DEBUG    = 2'd2;

    localparam int unsigned SIM_MSG_HOLD = 16;

    typedef enum logic [1:0] {
        ST_SCORE = 2'd0,
        ST_MSG   = 2'd1,
        ST_DEBUG = 2'd2
    } state_e;

    // Packs the five BCD score digits into d0..d4 (d0 in bits [4:0]);
    // d5..d7 are always blank.
    function automatic logic [39:0] score_view(input logic [19:0] bcd);
        logic [39:0] v;
`ifdef SEGARB_LZB_EN
        logic        seen;
`endif
        v = {8{DIG_BLANK}};
`ifdef SEGARB_LZB_EN
        // Scan from the most significant digit; ones digit always shown.
        seen = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            if (bcd[(4 - k) * 4 +: 4] != 4'd0 || k == 4)
                seen = 1'b1;
            if (seen)
                v[(4 - k) * 5 +: 5] = {1'b0, bcd[(4 - k) * 4 +: 4]};
        end
`else
        for (int unsigned k = 0; k < 5; k++)
            v[k * 5 +: 5] = {1'b0, bcd[k * 4 +: 4]};
`endif
        return v;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble: 16-bit binary to five BCD digits.
//   clk, reset : clock, synchronous active-high reset
//   start      : sample bin and begin a conversion (ignored while busy)
//   bin        : binary input
//   busy       : conversion in progress (iterations plus commit cycle)
//   done       : high in the cycle whose closing edge commits bcd
//   bcd        : last committed result, digit 0 in [3:0]
// Timing: start at edge N, iterations at N+1..N+16, bcd updated at N+17.
// ---------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [15:0] sh_q;
    logic [19:0] work_q;
    logic [19:0] work_d;
    logic [19:0] bcd_q;
    logic [19:0] adj;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the
    // next binary bit.
    always_comb begin
        adj = work_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (work_q[i * 4 +: 4] >= 4'd5)
                adj[i * 4 +: 4] = work_q[i * 4 +: 4] + 4'd3;
        end
        work_d = {adj[18:0], sh_q[15]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            work_q <= '0;
            bcd_q  <= '0;
        end else if (!busy_q) begin
            if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= 5'd16;
                sh_q   <= bin;
                work_q <= '0;
            end
        end else if (cnt_q != 5'd0) begin
            work_q <= work_d;
            sh_q   <= {sh_q[14:0], 1'b0};
            cnt_q  <= cnt_q - 5'd1;
        end else begin
            bcd_q  <= work_q;
            busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == 5'd0);
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Time-shares the 8-digit seven-segment display between the score
// (background), timed one-shot messages and a debug override
// (priority debug > message > score).
//   clk, reset        : clock, synchronous active-high reset
//   score             : binary score, converted to BCD in the background
//   msg_req/msg_ack   : level request / one-cycle latch acknowledge
//   msg_digits/msg_dp : message digit codes ([4:0] = digit 0) and points
//   msg_busy          : a message is latched (showing or paused)
//   dbg_en/dbg_digits : debug override and its digit codes
//   d0..d7, dp        : registered digit codes and decimal points
//   src               : current source (0 score, 1 message, 2 debug)
// Parameters: SIMULATE (1 forces a 16-cycle hold), MSG_HOLD (hold cycles).
// Build option: SEGARB_LZB_EN enables leading-zero blanking of the score.
// ---------------------------------------------------------------------------
module seg_display_arbiter
    import segarb_pkg::*;
#(
    parameter int          SIMULATE = 0,
    parameter int unsigned MSG_HOLD = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] score,
    input  logic        msg_req,
    input  logic [39:0] msg_digits,
    input  logic [7:0]  msg_dp,
    output logic        msg_ack,
    output logic        msg_busy,
    input  logic        dbg_en,
    input  logic [39:0] dbg_digits,
    output logic [4:0]  d0,
    output logic [4:0]  d1,
    output logic [4:0]  d2,
    output logic [4:0]  d3,
    output logic [4:0]  d4,
    output logic [4:0]  d5,
    output logic [4:0]  d6,
    output logic [4:0]  d7,
    output logic [7:0]  dp,
    output logic [1:0]  src
);

    localparam int unsigned HOLD      = (SIMULATE != 0) ? SIM_MSG_HOLD : MSG_HOLD;
    localparam logic [31:0] HOLD_LOAD = 32'(HOLD - 1);

    // Converter interface
    logic        conv_busy;
    logic        conv_done;
    logic        conv_start;
    logic [19:0] conv_bcd;
    logic [15:0] sample_q;
    logic [15:0] last_q;
    logic [39:0] score_disp;

    // Arbiter state
    state_e      state_q;
    logic        busy_q;
    logic        ack_pend_q;
    logic [31:0] hold_q;
    logic [39:0] mdig_q;
    logic [7:0]  mdp_q;

    // Output registers
    logic [39:0] disp_q;
    logic [7:0]  dp_q;
    logic [1:0]  src_q;
    logic        ack_q;
    logic        busyo_q;

    assign conv_start = !conv_busy && (score != last_q);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // last_q only advances on commit so an unchanged score is never
    // reconverted, and a change during a conversion is picked up once idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            last_q   <= '0;
        end else begin
            if (conv_start)
                sample_q <= score;
            if (conv_done)
                last_q <= sample_q;
        end
    end

    always_comb begin
        score_disp = score_view(conv_bcd);
    end

    // Output registers are loaded from the pre-edge state, so every source
    // change becomes visible one edge after the state register moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SCORE;
            busy_q     <= 1'b0;
            ack_pend_q <= 1'b0;
            hold_q     <= '0;
            mdig_q     <= '0;
            mdp_q      <= '0;
            disp_q     <= score_view(20'h0);
            dp_q       <= '0;
            src_q      <= SRC_SCORE;
            ack_q      <= 1'b0;
            busyo_q    <= 1'b0;
        end else begin
            ack_pend_q <= 1'b0;
            if (dbg_en) begin
                // The cycle spent in MSG before the switch still counts; a
                // message on its last cycle is finished rather than paused.
                if (state_q == ST_MSG) begin
                    if (hold_q == '0)
                        busy_q <= 1'b0;
                    else
                        hold_q <= hold_q - 32'd1;
                end
                state_q <= ST_DEBUG;
            end else if (busy_q) begin
                if (state_q != ST_MSG) begin
                    state_q <= ST_MSG;
                end else if (hold_q == '0) begin
                    busy_q  <= 1'b0;
                    state_q <= ST_SCORE;
                end else begin
                    hold_q  <= hold_q - 32'd1;
                end
            end else if (msg_req) begin
                mdig_q     <= msg_digits;
                mdp_q      <= msg_dp;
                hold_q     <= HOLD_LOAD;
                busy_q     <= 1'b1;
                ack_pend_q <= 1'b1;
                state_q    <= ST_MSG;
            end else begin
                state_q <= ST_SCORE;
            end

            ack_q   <= ack_pend_q;
            busyo_q <= busy_q;
            case (state_q)
                ST_MSG: begin
                    src_q  <= SRC_MSG;
                    disp_q <= mdig_q;
                    dp_q   <= mdp_q;
                end
                ST_DEBUG: begin
                    src_q  <= SRC_DEBUG;
                    disp_q <= dbg_digits;
                    dp_q   <= '0;
                end
                default: begin
                    src_q  <= SRC_SCORE;
                    disp_q <= score_disp;
                    dp_q   <= '0;
                end
            endcase
        end
    end

    assign d0       = disp_q[4:0];
    assign d1       = disp_q[9:5];
    assign d2       = disp_q[14:10];
    assign d3       = disp_q[19:15];
    assign d4       = disp_q[24:20];
    assign d5       = disp_q[29:25];
    assign d6       = disp_q[34:30];
    assign d7       = disp_q[39:35];
    assign dp       = dp_q;
    assign src      = src_q;
    assign msg_ack  = ack_q;
    assign msg_busy = busyo_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter
// Self-checking bench for seg_display_arbiter (SIMULATE=1, 16-cycle hold).
// Honours SEGARB_LZB_EN for the expected score digits.
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] score = '0;
    logic        msg_req = 1'b0;
    logic [39:0] msg_digits = '0;
    logic [7:0]  msg_dp = '0;
    logic        dbg_en = 1'b0;
    logic [39:0] dbg_digits = '0;
    logic        msg_ack, msg_busy;
    logic [4:0]  d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0]  dp;
    logic [1:0]  src;

    seg_display_arbiter #(
        .SIMULATE (1),
        .MSG_HOLD (1000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .score      (score),
        .msg_req    (msg_req),
        .msg_digits (msg_digits),
        .msg_dp     (msg_dp),
        .msg_ack    (msg_ack),
        .msg_busy   (msg_busy),
        .dbg_en     (dbg_en),
        .dbg_digits (dbg_digits),
        .d0 (d0), .d1 (d1), .d2 (d2), .d3 (d3),
        .d4 (d4), .d5 (d5), .d6 (d6), .d7 (d7),
        .dp         (dp),
        .src        (src)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    // Reference converter: a score seen at edge t while idle is displayed
    // from edge t+18, and the next sample may happen at edge t+18.
    int unsigned m_t    = 0;
    int unsigned m_idle = 0;
    int unsigned m_vis  = 0;
    bit          m_pend = 0;
    int unsigned m_pval = 0;
    int unsigned m_last = 0;
    int unsigned m_disp = 0;

    typedef struct {
        logic [15:0] score;
        logic [19:0] bcd;
    } vec_t;
    vec_t tbl [13];

    localparam logic [39:0] MD1 = {5'h10, 5'h0A, 5'h00, 5'h0E, 5'h1F, 5'h0F, 5'h0A, 5'h06};
    localparam logic [39:0] MD2 = {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08};
    localparam logic [39:0] DD  = {5'h0D, 5'h0E, 5'h0B, 5'h09, 5'h1F, 5'h11, 5'h12, 5'h13};

    function automatic logic [39:0] view_of(input int unsigned v);
        logic [39:0] r;
        int unsigned p;
        r = {8{5'h1F}};
        p = 1;
        for (int unsigned i = 0; i < 5; i++) begin
`ifdef SEGARB_LZB_EN
            if (i == 0 || v >= p)
                r[i * 5 +: 5] = 5'((v / p) % 10);
`else
            r[i * 5 +: 5] = 5'((v / p) % 10);
`endif
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int unsigned bcd_val(input logic [19:0] b);
        int unsigned v;
        int unsigned p;
        v = 0;
        p = 1;
        for (int unsigned i = 0; i < 5; i++) begin
            v = v + p * int'(b[i * 4 +: 4]);
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [51:0] obs();
        return {d7, d6, d5, d4, d3, d2, d1, d0, dp, src, msg_ack, msg_busy};
    endfunction

    function automatic logic [51:0] sc_exp(input int unsigned v);
        return {view_of(v), 8'h00, 2'd0, 1'b0, 1'b0};
    endfunction

    function automatic logic [51:0] msg_exp(input logic [39:0] dig, input logic [7:0] p, input logic ack);
        return {dig, p, 2'd1, ack, 1'b1};
    endfunction

    function automatic logic [51:0] dbg_exp(input logic busy);
        return {dbg_digits, 8'h00, 2'd2, 1'b0, busy};
    endfunction

    task automatic chk(input string name, input logic [51:0] exp);
        logic [51:0] act;
        act = obs();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        m_t++;
        if (reset) begin
            m_last = 0;
            m_pend = 0;
            m_disp = 0;
            m_idle = m_t + 1;
        end else begin
            if (m_pend && m_t == m_vis) begin
                m_disp = m_pval;
                m_pend = 0;
            end
            if (m_t >= m_idle && int'(score) != m_last) begin
                m_last = score;
                m_pval = score;
                m_pend = 1;
                m_vis  = m_t + 18;
                m_idle = m_t + 18;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    initial begin
        logic [39:0] prev_view;
        logic [39:0] new_view;

        tbl[0]  = '{16'd12,    20'h00012};
        tbl[1]  = '{16'd65535, 20'h65535};
        tbl[2]  = '{16'd9,     20'h00009};
        tbl[3]  = '{16'd100,   20'h00100};
        tbl[4]  = '{16'd10,    20'h00010};
        tbl[5]  = '{16'd99,    20'h00099};
        tbl[6]  = '{16'd1000,  20'h01000};
        tbl[7]  = '{16'd10000, 20'h10000};
        tbl[8]  = '{16'd40960, 20'h40960};
        tbl[9]  = '{16'd4095,  20'h04095};
        tbl[10] = '{16'd59999, 20'h59999};
        tbl[11] = '{16'd0,     20'h00000};
        tbl[12] = '{16'd7,     20'h00007};
        dbg_digits = DD;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("reset_view", {view_of(0), 8'h00, 2'd0, 1'b0, 1'b0});
        reset = 1'b0;

        // Randomized score changes against the reference converter
        for (int i = 0; i < 500; i++) begin
            step();
            chk("rand_score", sc_exp(m_disp));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    score = 16'($urandom_range(0, 65535));
                else
                    score = 16'($urandom_range(0, 120));
            end
        end

        // Settle at 0, then table of conversions with exact latency edges
        score = 16'd0;
        for (int i = 0; i < 40; i++) step();
        chk("settle_zero", sc_exp(0));
        prev_view = view_of(0);
        for (int unsigned v = 0; v < 13; v++) begin
            score    = tbl[v].score;
            new_view = view_of(bcd_val(tbl[v].bcd));
            for (int k = 0; k < 18; k++) step();
            chk("tbl_before_N18", {prev_view, 8'h00, 2'd0, 1'b0, 1'b0});
            step();
            chk("tbl_at_N18", {new_view, 8'h00, 2'd0, 1'b0, 1'b0});
            prev_view = new_view;
        end

        // 100 then 200 three cycles later: no intermediate values
        score = 16'd100;
        for (int k = 0; k <= 40; k++) begin
            step();
            if (k < 18)      chk("chg_old", sc_exp(7));
            else if (k < 36) chk("chg_100", sc_exp(100));
            else             chk("chg_200", sc_exp(200));
            if (k == 2) score = 16'd200;
        end

        // Message with a second request queued during the hold
        msg_digits = MD1; msg_dp = 8'h81; msg_req = 1'b1;
        step();
        chk("msgA_edgeM", sc_exp(200));
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("msgA_show", msg_exp(MD1, 8'h81, k == 1));
            if (k == 1) begin msg_digits = MD2; msg_dp = 8'h3C; end
        end
        step();
        chk("msgA_return", sc_exp(200));
        step();
        chk("msgA2_ack", msg_exp(MD2, 8'h3C, 1'b1));
        msg_req = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            step();
            chk("msgA2_show", msg_exp(MD2, 8'h3C, 1'b0));
        end
        step();
        chk("msgA2_return", sc_exp(200));

        // Request and debug together: debug wins, ack after release
        msg_digits = MD1; msg_dp = 8'h55; msg_req = 1'b1; dbg_en = 1'b1;
        step();
        chk("dbgB_edgeE", sc_exp(200));
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("dbgB_show", dbg_exp(1'b0));
            if (k == 4) dbg_en = 1'b0;
        end
        step();
        chk("dbgB_ack", msg_exp(MD1, 8'h55, 1'b1));
        msg_req = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            step();
            chk("dbgB_msg", msg_exp(MD1, 8'h55, 1'b0));
        end
        step();
        chk("dbgB_return", sc_exp(200));

        // Debug pause after 8 message cycles, 10 debug cycles, 8 left
        msg_digits = MD2; msg_dp = 8'h0F; msg_req = 1'b1;
        step();
        chk("pauseC_edgeM", sc_exp(200));
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("pauseC_first", msg_exp(MD2, 8'h0F, k == 1));
            if (k == 1) msg_req = 1'b0;
            if (k == 7) dbg_en = 1'b1;
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            chk("pauseC_dbg", dbg_exp(1'b1));
            if (j == 9) dbg_en = 1'b0;
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("pauseC_rest", msg_exp(MD2, 8'h0F, 1'b0));
        end
        step();
        chk("pauseC_return", sc_exp(200));

        // Reset in the middle of a message
        score = 16'd7;
        msg_digits = MD1; msg_dp = 8'hF0; msg_req = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("rstD_show", msg_exp(MD1, 8'hF0, k == 1));
            if (k == 1) msg_req = 1'b0;
        end
        reset = 1'b1;
        step();
        chk("rstD_reset", sc_exp(0));
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            chk("rstD_after", sc_exp(m_disp));
        end
        chk("rstD_final", sc_exp(7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
